// File: rtl/mips_pkg.sv
// Shared MIPS register-file types and widths for the writeback front end.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Synchronous FIFO of pending slow-path writebacks; head is visible
// combinationally on o_dout while o_empty is low.
module rf_wb_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    i_push,
  input  wb_req_t i_din,
  input  logic    i_pop,
  output wb_req_t o_dout,
  output logic    o_full,
  output logic    o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_req_t          r_mem [DEPTH];
  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_din;
  end

  assign o_dout  = r_mem[r_rd_ptr[PTR_W-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

endmodule

// File: rtl/rf_write_arbiter.sv
// Single write-port arbiter for the MIPS register file: fast datapath vs
// buffered slow results, with RAW scoreboard. RF_BYPASS_EN adds read forwarding.
module rf_write_arbiter
  import mips_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef RF_BYPASS_EN
  input  logic [REG_ADDR_W-1:0] rd_addr_1,
  input  logic [REG_ADDR_W-1:0] rd_addr_2,
  output logic                  fwd_hit_1,
  output logic                  fwd_hit_2,
  output logic [DATA_W-1:0]     fwd_data_1,
  output logic [DATA_W-1:0]     fwd_data_2,
`endif
  input  logic                  fast_valid,
  input  logic [REG_ADDR_W-1:0] fast_addr,
  input  logic [DATA_W-1:0]     fast_data,
  input  logic                  slow_valid,
  output logic                  slow_ready,
  input  logic [REG_ADDR_W-1:0] slow_addr,
  input  logic [DATA_W-1:0]     slow_data,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_addr,
  output logic                  reg_write,
  output logic [REG_ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0]     write_data,
  output logic                  fast_hold,
  output logic [NUM_REGS-1:0]   pending,
  output logic                  wb_err
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0]    r_starve;
  logic [NUM_REGS-1:0] r_pending;
  logic                r_wb_err;

  wb_req_t             w_head;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic                w_fast_win;
  logic [NUM_REGS-1:0] w_set_mask;
  logic [NUM_REGS-1:0] w_clr_mask;

  assign fast_hold  = !w_empty && (r_starve >= CNT_W'(STARVE_MAX));
  assign w_fast_win = fast_valid && (fast_addr != ZERO_REG) && !fast_hold;
  assign w_pop      = !w_empty && !w_fast_win;
  assign slow_ready = !w_full;
  // Writes to $zero are acknowledged but never buffered.
  assign w_push     = slow_valid && slow_ready && (slow_addr != ZERO_REG);

  rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push),
    .i_din   ('{addr: slow_addr, data: slow_data}),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    reg_write  = 1'b0;
    write_addr = ZERO_REG;
    write_data = '0;
    if (w_fast_win) begin
      reg_write  = 1'b1;
      write_addr = fast_addr;
      write_data = fast_data;
    end else if (!w_empty) begin
      reg_write  = 1'b1;
      write_addr = w_head.addr;
      write_data = w_head.data;
    end
  end

  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (issue_valid && (issue_addr != ZERO_REG)) w_set_mask[issue_addr] = 1'b1;
    if (w_pop) w_clr_mask[w_head.addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve  <= '0;
      r_pending <= '0;
      r_wb_err  <= 1'b0;
    end else begin
      if (w_empty || w_pop)
        r_starve <= '0;
      else if (r_starve < CNT_W'(STARVE_MAX))
        r_starve <= r_starve + 1'b1;
      // Set is OR-ed after clear so a same-cycle reissue keeps the bit.
      r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
      if ((fast_valid && fast_hold) || (w_fast_win && r_pending[fast_addr]))
        r_wb_err <= 1'b1;
    end
  end

  assign pending = r_pending;
  assign wb_err  = r_wb_err;

`ifdef RF_BYPASS_EN
  assign fwd_hit_1  = reg_write && (write_addr == rd_addr_1) && (rd_addr_1 != ZERO_REG);
  assign fwd_hit_2  = reg_write && (write_addr == rd_addr_2) && (rd_addr_2 != ZERO_REG);
  assign fwd_data_1 = write_data;
  assign fwd_data_2 = write_data;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_rf_write_arbiter;
  import mips_pkg::*;

  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  fast_valid;
  logic [REG_ADDR_W-1:0] fast_addr;
  logic [DATA_W-1:0]     fast_data;
  logic                  slow_valid;
  logic                  slow_ready;
  logic [REG_ADDR_W-1:0] slow_addr;
  logic [DATA_W-1:0]     slow_data;
  logic                  issue_valid;
  logic [REG_ADDR_W-1:0] issue_addr;
  logic                  reg_write;
  logic [REG_ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0]     write_data;
  logic                  fast_hold;
  logic [NUM_REGS-1:0]   pending;
  logic                  wb_err;

  rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk         (clk),
    .reset       (reset),
    .fast_valid  (fast_valid),
    .fast_addr   (fast_addr),
    .fast_data   (fast_data),
    .slow_valid  (slow_valid),
    .slow_ready  (slow_ready),
    .slow_addr   (slow_addr),
    .slow_data   (slow_data),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .reg_write   (reg_write),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .fast_hold   (fast_hold),
    .pending     (pending),
    .wb_err      (wb_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: queued slow results, blocked-cycle count, pending set, error flag.
  wb_req_t      m_q[$];
  int           m_starve;
  bit [31:0]    m_pend;
  bit           m_err;
  bit           m_hold;
  bit           m_fast;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input bit fv, input int fa, input logic [31:0] fd,
                       input bit sv, input int sa, input logic [31:0] sd,
                       input bit iv, input int ia);
    fast_valid  = fv;
    fast_addr   = REG_ADDR_W'(fa);
    fast_data   = fd;
    slow_valid  = sv;
    slow_addr   = REG_ADDR_W'(sa);
    slow_data   = sd;
    issue_valid = iv;
    issue_addr  = REG_ADDR_W'(ia);
  endtask

  // Drive one cycle's inputs and compare all outputs with the model.
  task automatic apply(input bit fv, input int fa, input logic [31:0] fd,
                       input bit sv, input int sa, input logic [31:0] sd,
                       input bit iv, input int ia);
    bit exp_rw;
    drive(fv, fa, fd, sv, sa, sd, iv, ia);
    #1;
    m_hold = (m_q.size() != 0) && (m_starve >= STARVE_MAX);
    m_fast = fv && (fa != 0) && !m_hold;
    exp_rw = m_fast || (m_q.size() != 0);
    check("slow_ready", 32'(slow_ready), 32'(m_q.size() < DEPTH));
    check("fast_hold", 32'(fast_hold), 32'(m_hold));
    check("reg_write", 32'(reg_write), 32'(exp_rw));
    if (m_fast) begin
      check("write_addr", 32'(write_addr), 32'(fa));
      check("write_data", write_data, fd);
    end else if (exp_rw) begin
      check("write_addr", 32'(write_addr), 32'(m_q[0].addr));
      check("write_data", write_data, m_q[0].data);
    end
    check("pending", pending, m_pend);
    check("wb_err", 32'(wb_err), 32'(m_err));
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic tick();
    bit      ready;
    bit      popped;
    bit      was_empty;
    wb_req_t h;
    ready     = m_q.size() < DEPTH;
    was_empty = m_q.size() == 0;
    popped    = !m_fast && !was_empty;
    if (fast_valid && m_hold) m_err = 1'b1;
    if (m_fast && m_pend[fast_addr]) m_err = 1'b1;
    if (popped) begin
      h = m_q.pop_front();
      m_pend[h.addr] = 1'b0;
    end
    if (slow_valid && ready && slow_addr != 0) m_q.push_back('{addr: slow_addr, data: slow_data});
    if (issue_valid && issue_addr != 0) m_pend[issue_addr] = 1'b1;
    if (was_empty || popped) m_starve = 0;
    else if (m_starve < STARVE_MAX) m_starve++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step(input bit fv, input int fa, input logic [31:0] fd,
                      input bit sv, input int sa, input logic [31:0] sd,
                      input bit iv, input int ia);
    apply(fv, fa, fd, sv, sa, sd, iv, ia);
    tick();
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    check("rst_reg_write", 32'(reg_write), 0);
    check("rst_fast_hold", 32'(fast_hold), 0);
    check("rst_slow_ready", 32'(slow_ready), 1);
    check("rst_pending", pending, 0);
    check("rst_wb_err", 32'(wb_err), 0);
    m_q.delete();
    m_starve = 0;
    m_pend   = '0;
    m_err    = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int held;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    do_reset();

    // Fast path is combinational; $zero writes are suppressed.
    apply(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    check("tp_fast_data", write_data, 32'hDEADBEEF);
    tick();
    apply(1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    check("tp_fast_zero", 32'(reg_write), 0);
    tick();

    // Slow write with idle fast path and scoreboard clear.
    step(0, 0, 0, 0, 0, 0, 1, 9);
    apply(0, 0, 0, 1, 9, 32'h1234, 0, 0);
    check("tp_pend9_set", 32'(pending[9]), 1);
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    check("tp_slow_data", write_data, 32'h1234);
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    check("tp_pend9_clr", 32'(pending[9]), 0);
    tick();

    // Backpressure and starvation under continuous fast writes.
    held = 0;
    for (int c = 0; c < 12; c++) begin
      bit offer;
      offer = held < 3;
      apply(1, 1, 32'(c), offer, 10 + held, 32'hA000 + 32'(held), 0, 0);
      if (c == 2) check("tp_bp_ready", 32'(slow_ready), 0);
      if (c == 5) check("tp_starve_hold", 32'(fast_hold), 1);
      if (offer && m_q.size() < DEPTH) held++;
      tick();
    end
    check("tp_starve_err", 32'(wb_err), 1);
    check("tp_bp_all_taken", 32'(held), 3);

    // Same-cycle set and clear on r3, then WAW fast write.
    do_reset();
    step(0, 0, 0, 1, 3, 32'h33, 1, 3);
    step(0, 0, 0, 0, 0, 0, 1, 3);
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    check("tp_set_wins", 32'(pending[3]), 1);
    tick();
    step(1, 3, 32'h3333, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    check("tp_waw_err", 32'(wb_err), 1);
    check("tp_waw_pend", 32'(pending[3]), 1);
    tick();

    // Reset with two queued entries; nothing may reappear afterwards.
    step(1, 2, 1, 1, 20, 32'hBB01, 1, 20);
    step(1, 2, 2, 1, 21, 32'hBB02, 1, 21);
    do_reset();
    for (int c = 0; c < 3; c++) begin
      apply(0, 0, 0, 0, 0, 0, 0, 0);
      check("tp_post_rst_idle", 32'(reg_write), 0);
      tick();
    end

    // Random traffic on a small address range to provoke collisions.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 249) == 0) do_reset();
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 3) == 0, int'($urandom_range(0, 7)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Single-writer front end for the 32x32 MIPS register file's one write port. Merges writebacks from the single-cycle datapath (fast path, never stalls) with results from multi-cycle units such as mult/div and the load unit (slow path, valid/ready). Buffers slow results, drops writes to $zero, and keeps a pending-register scoreboard so issue logic can stall on RAW hazards against in-flight slow results.

## Interface
- DEPTH, 2: slow-path FIFO entries (power of two, ≥2)
- STARVE_MAX, 4: consecutive blocked cycles before the slow path forces a drain
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- fast_valid  in  1  datapath writeback this cycle
- fast_addr  in  5  fast destination register
- fast_data  in  32  fast write data
- slow_valid  in  1  slow result offered
- slow_ready  out  1  FIFO can accept; equals !full
- slow_addr  in  5  slow destination register
- slow_data  in  32  slow write data
- issue_valid  in  1  slow op issued; marks its destination pending
- issue_addr  in  5  destination of the issued slow op
- reg_write  out  1  register file write enable
- write_addr  out  5  register file write address
- write_data  out  32  register file write data
- fast_hold  out  1  datapath must not write back this cycle
- pending  out  32  scoreboard; bit 0 always 0
- wb_err  out  1  sticky protocol-error flag

## Operation
- Write port is combinational: fast wins when fast_valid && fast_addr!=0 && !fast_hold; otherwise FIFO head when non-empty; otherwise reg_write=0.
- A FIFO pop occurs exactly when the head drives the port.
- Enqueue on slow_valid && slow_ready. slow_addr==0 is accepted and discarded: never enqueued, no write.
- slow_valid while !slow_ready: no transfer; producer holds.
- Starvation counter increments on each cycle the FIFO is non-empty and not popped, and clears on pop or when empty. At STARVE_MAX, fast_hold=1 and the head drains that cycle.
- fast_valid during fast_hold: fast write lost, wb_err set.
- Scoreboard: issue_valid && issue_addr!=0 sets the bit. A slow write reaching the port clears its bit. Set and clear on the same address in the same cycle: set wins.
- A fast write to an address whose pending bit is set (WAW): the write is performed, the bit stays set, wb_err set.
- wb_err clears only on reset.

## Timing
- Fast path latency: 0 cycles (combinational to the port).
- Slow path latency: ≥1 cycle; an entry enqueued in cycle N can drive the port in cycle N+1.
- Simultaneous enqueue and pop when full: slow_ready is still 0 (no pass-through).
- pending, wb_err, the FIFO and the counter are registered and update on posedge clk.
- Reset, including mid-operation: FIFO empty, counter 0, pending=0, wb_err=0, reg_write=0, fast_hold=0, slow_ready=1. Queued slow results are discarded.

## Configuration
- RF_BYPASS_EN defined: adds inputs rd_addr_1/rd_addr_2 (5) and outputs fwd_hit_1/fwd_hit_2 (1) and fwd_data_1/fwd_data_2 (32).
  - fwd_hit_n=1 when reg_write && write_addr==rd_addr_n && rd_addr_n!=0; fwd_data_n=write_data.
  - This gives same-cycle forwarding for the read-during-write case.
- RF_BYPASS_EN undefined: these ports do not exist; readers see new data the cycle after the write.

## Structure
- mips_pkg holds REG_ADDR_W=5, DATA_W=32, ZERO_REG=5'd0 and the wb_req_t struct {addr, data}.
- One sub-module, rf_wb_fifo: parameterized synchronous FIFO of wb_req_t with full/empty flags and async active-high reset.

## Test plan
- Fast only: fast_valid, addr 5, data 0xDEADBEEF → same cycle reg_write=1, write_addr=5, write_data=0xDEADBEEF. Repeat with addr 0 → reg_write=0.
- Slow with idle fast: issue addr 9 → pending[9]=1; slow write addr 9, data 0x1234 → on port the next cycle; pending[9]=0 the cycle after.
- Backpressure: offer 3 slow writes while fast_valid is held high → slow_ready=0 after 2 accepted; the third is held, no loss.
- Starvation: FIFO non-empty with fast_valid every cycle → fast_hold=1 on the 5th blocked cycle (STARVE_MAX=4) and the head drains; fast_valid in that cycle → wb_err=1.
- Hazards: issue addr 3 and clear addr 3 in the same cycle → pending[3] stays 1. Fast write to addr 3 → write performed, wb_err=1.
- Assert reset with 2 queued entries → all outputs return to reset values, and no queued write appears after release.
